minmax_tracker_8bit: RTL
========================

Name: minmax_tracker_8bit

Overview:
- Sequential stage directly downstream of the 8-bit comparator (EE = equal, GG = A greater than B).
- Accepts a stream of 8-bit samples and drives each sample onto the comparator's A/B inputs against the stored running maximum, then against the stored running minimum.
- Waits a programmable settle time for the gate-level comparator outputs to stabilise, then samples EE/GG and updates its running statistics.
- Reports max, min, sample count and equal-to-max count.

Parameters:
- SETTLE_CYCLES, 60, clock cycles the comparator inputs are held before EE/GG are sampled (60 x 10 ns = 600 ns); legal range 1..255.
- COUNT_W, 8, width of the sample and equal counters.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data holds a sample.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  8  unsigned sample.
- cmp_a  output  8  to comparator input A (the sample under test).
- cmp_b  output  8  to comparator input B (stored max or min).
- cmp_eq  input  1  comparator EE output.
- cmp_gt  input  1  comparator GG output (A > B).
- max_val  output  8  running maximum.
- min_val  output  8  running minimum.
- sample_cnt  output  COUNT_W  samples processed, saturating.
- eq_cnt  output  COUNT_W  samples equal to the max at compare time, saturating.
- res_valid  output  1  one-cycle pulse: statistics updated.
- cmp_err  output  1  sticky flag: EE and GG both seen high at a sample point.

Behaviour:
- Reset: one clock with rst=1 clears everything.
  - State goes to IDLE.
  - max_val, min_val, cmp_a, cmp_b, sample_cnt and eq_cnt go to 0.
  - res_valid and cmp_err go to 0.
  - The internal has_data flag goes to 0.
  - in_ready is 1 from the first cycle after reset.
- Reset mid-operation: same effect as above. The in-flight sample is discarded and no res_valid is produced.
- States are IDLE, CMP_MAX, CMP_MIN and DONE. in_ready = 1 only in IDLE.
- IDLE:
  - A transfer occurs when in_valid and in_ready are both 1. The sample is latched into s_reg.
  - If has_data = 0: max_val <= in_data, min_val <= in_data, has_data <= 1, next state DONE. No comparison is made.
  - Otherwise: cmp_a <= in_data, cmp_b <= max_val, settle counter <= SETTLE_CYCLES-1, next state CMP_MAX.
- CMP_MAX:
  - cmp_a and cmp_b are held stable. The counter decrements each cycle.
  - On the cycle the counter reads 0, cmp_eq and cmp_gt are sampled.
  - gt=1, eq=0: max_val <= s_reg.
  - eq=1: eq_cnt increments (saturating).
  - gt=1 and eq=1: treated as equal, and cmp_err <= 1.
  - Same cycle: cmp_b <= min_val, counter reloads, next state CMP_MIN.
- CMP_MIN:
  - Same settle rule as CMP_MAX.
  - At the sample point: eq=0 and gt=0 means sample < min, so min_val <= s_reg.
  - eq=1 and gt=1 sets cmp_err; min_val is unchanged.
  - Next state DONE.
- DONE:
  - res_valid = 1 for exactly this cycle.
  - sample_cnt increments, saturating at all-ones.
  - Next state IDLE.
- Latency, with transfer at cycle T:
  - First sample: DONE at T+1.
  - Later samples: CMP_MAX spans T+1..T+S, CMP_MIN spans T+S+1..T+2S, DONE at T+2S+1, where S = SETTLE_CYCLES.
  - Next accept possible at T+2S+2.
- cmp_a and cmp_b keep their last values in IDLE and DONE. They change only on the transfer cycle and on the CMP_MAX to CMP_MIN transition.
- max_val and min_val change only at the sample points or on the first sample. They are stable whenever res_valid = 1.
- EE/GG are ignored outside the sample-point cycle, so glitches are tolerated.
- Counter saturation: sample_cnt and eq_cnt hold at 2^COUNT_W-1 and never wrap. The update path is unaffected.
- in_valid while in_ready = 0: the data is not consumed. The upstream stage must hold it.

Test Plan (bench uses SETTLE_CYCLES=4 and a behavioural comparator model with 25 ns output delay):
- Reset, then send 0x55 -> res_valid at T+1; max_val = min_val = 0x55; sample_cnt = 1; eq_cnt = 0.
- Send 0x80 then 0x10:
  - After 0x80: max_val = 0x80, min_val = 0x55.
  - After 0x10: max_val = 0x80, min_val = 0x10.
  - Each res_valid arrives exactly 9 cycles after its transfer; in_ready stays 0 for those 9 cycles.
- Send 0x80 again after the above -> eq_cnt = 1; max_val and min_val unchanged; sample_cnt = 4.
- Force the model to glitch EE/GG during settle, then settle to the correct value 2 cycles before the sample point -> result matches the settled value; cmp_err stays 0.
- Force eq = gt = 1 at the CMP_MAX sample point for sample 0xFF with max 0x80 -> max_val stays 0x80; eq_cnt increments; cmp_err = 1 and stays 1 until rst.
- Assert rst in the 2nd CMP_MIN cycle -> next cycle all outputs are 0 and in_ready = 1; no res_valid. A following sample 0x33 is treated as first: max_val = min_val = 0x33.

Source files
------------

// File: rtl/minmax_tracker_8bit_if.sv
// Bus bundle between the min/max tracker, its upstream sample source, the external
// comparator and the statistics consumer.
interface minmax_tracker_8bit_if #(
    parameter int unsigned COUNT_W = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         in_data;
    logic [7:0]         cmp_a;
    logic [7:0]         cmp_b;
    logic               cmp_eq;
    logic               cmp_gt;
    logic [7:0]         max_val;
    logic [7:0]         min_val;
    logic [COUNT_W-1:0] sample_cnt;
    logic [COUNT_W-1:0] eq_cnt;
    logic               res_valid;
    logic               cmp_err;

    modport master (
        output in_valid, in_data, cmp_eq, cmp_gt,
        input  in_ready, cmp_a, cmp_b, max_val, min_val, sample_cnt, eq_cnt, res_valid, cmp_err
    );

    modport slave (
        input  in_valid, in_data, cmp_eq, cmp_gt,
        output in_ready, cmp_a, cmp_b, max_val, min_val, sample_cnt, eq_cnt, res_valid, cmp_err
    );
endinterface

// File: rtl/minmax_tracker_8bit.sv
// Running max/min tracker that drives an external gate-level comparator and samples its
// EE/GG outputs after a programmable settle time.
module minmax_tracker_8bit #(
    parameter int unsigned SETTLE_CYCLES = 60,
    parameter int unsigned COUNT_W       = 8
) (
    input logic                 clk,
    input logic                 rst,
    minmax_tracker_8bit_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StCmpMax, StCmpMin, StDone} state_e;

    localparam logic [7:0] SettleLoad = 8'(SETTLE_CYCLES - 1);

    state_e             state_q, state_d;
    logic [7:0]         s_q, s_d;
    logic [7:0]         max_q, max_d;
    logic [7:0]         min_q, min_d;
    logic [7:0]         cmp_a_q, cmp_a_d;
    logic [7:0]         cmp_b_q, cmp_b_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [COUNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [COUNT_W-1:0] eq_cnt_q, eq_cnt_d;
    logic               err_q, err_d;
    logic               has_data_q, has_data_d;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            s_q          <= '0;
            max_q        <= '0;
            min_q        <= '0;
            cmp_a_q      <= '0;
            cmp_b_q      <= '0;
            cnt_q        <= '0;
            sample_cnt_q <= '0;
            eq_cnt_q     <= '0;
            err_q        <= 1'b0;
            has_data_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            max_q        <= max_d;
            min_q        <= min_d;
            cmp_a_q      <= cmp_a_d;
            cmp_b_q      <= cmp_b_d;
            cnt_q        <= cnt_d;
            sample_cnt_q <= sample_cnt_d;
            eq_cnt_q     <= eq_cnt_d;
            err_q        <= err_d;
            has_data_q   <= has_data_d;
        end
    end

    // sample_cnt is bumped on entry to StDone so it already includes the sample
    // while res_valid is high.
    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        max_d        = max_q;
        min_d        = min_q;
        cmp_a_d      = cmp_a_q;
        cmp_b_d      = cmp_b_q;
        cnt_d        = cnt_q;
        sample_cnt_d = sample_cnt_q;
        eq_cnt_d     = eq_cnt_q;
        err_d        = err_q;
        has_data_d   = has_data_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    s_d = bus.in_data;
                    if (!has_data_q) begin
                        max_d        = bus.in_data;
                        min_d        = bus.in_data;
                        has_data_d   = 1'b1;
                        sample_cnt_d = sat_inc(sample_cnt_q);
                        state_d      = StDone;
                    end else begin
                        cmp_a_d = bus.in_data;
                        cmp_b_d = max_q;
                        cnt_d   = SettleLoad;
                        state_d = StCmpMax;
                    end
                end
            end
            StCmpMax: begin
                if (cnt_q == 8'd0) begin
                    // EE wins over GG; both high is a comparator fault.
                    if (bus.cmp_eq) begin
                        eq_cnt_d = sat_inc(eq_cnt_q);
                        if (bus.cmp_gt) err_d = 1'b1;
                    end else if (bus.cmp_gt) begin
                        max_d = s_q;
                    end
                    cmp_b_d = min_q;
                    cnt_d   = SettleLoad;
                    state_d = StCmpMin;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StCmpMin: begin
                if (cnt_q == 8'd0) begin
                    if (bus.cmp_eq && bus.cmp_gt) begin
                        err_d = 1'b1;
                    end else if (!bus.cmp_eq && !bus.cmp_gt) begin
                        min_d = s_q;
                    end
                    sample_cnt_d = sat_inc(sample_cnt_q);
                    state_d      = StDone;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.in_ready   = (state_q == StIdle);
    assign bus.res_valid  = (state_q == StDone);
    assign bus.cmp_a      = cmp_a_q;
    assign bus.cmp_b      = cmp_b_q;
    assign bus.max_val    = max_q;
    assign bus.min_val    = min_q;
    assign bus.sample_cnt = sample_cnt_q;
    assign bus.eq_cnt     = eq_cnt_q;
    assign bus.cmp_err    = err_q;

endmodule
